fir_stim_gen: RTL and testbench
===============================

Name: fir_stim_gen

Overview:
- Synthesizable stimulus source for the FIR datapath: on-chip replacement for the file-driven sample maker, usable in FPGA bring-up and gate-level benches without file I/O.
- Drives the filter's input side: DOUT/VOUT sample stream plus the 11 coefficient buses H0..H10.
- Paces samples with a programmable idle gap and flags END_SIM once the filter pipeline has drained.

Parameters:
- NB, 9, sample and coefficient width in bits (two's complement).
- N_SAMPLES, 1024, number of valid samples emitted per run (>=1).
- CNT_W, 16, width of the sample and drain counters; N_SAMPLES and DRAIN_CYCLES must be < 2^CNT_W.
- DRAIN_CYCLES, 16, idle cycles after the last sample before END_SIM.
- LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1.
- H_INIT, 11*NB bits, packed coefficients; H0 = bits [NB-1:0], H10 in the top slice.

Ports:
- CLK  in  1  clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- START  in  1  level; sampled in IDLE only.
- GAP_CFG  in  4  idle cycles between consecutive valid samples; latched on START.
- DOUT  out  NB  sample, valid when VOUT=1.
- VOUT  out  1  sample-valid strobe, one cycle per sample.
- H0..H10  out  NB each  coefficients, registered.
- END_SIM  out  1  run complete; sticky until reset.
- BUSY  out  1  high in RUN and DRAIN.

Behaviour:
- Reset (async, RST_n=0): state IDLE; DOUT=0, VOUT=0, END_SIM=0, BUSY=0; lfsr=LFSR_SEED; H0..H10 = H_INIT slices; counters=0.
- All outputs are registered. H0..H10 are constant after reset.
- IDLE: if START=1 at an edge, latch GAP_CFG into gap_r, set gap_cnt=0 and smp_cnt=0, go to RUN.
- RUN, every edge:
  - If gap_cnt=0: VOUT<=1, DOUT<=lfsr[NB-1:0], lfsr advances, smp_cnt+1, gap_cnt<=gap_r.
  - Else: VOUT<=0, gap_cnt-1, DOUT holds.
  - The edge that emits sample N_SAMPLES moves to DRAIN with drn_cnt=DRAIN_CYCLES.
- Spacing: consecutive VOUT pulses are exactly gap_r+1 cycles apart. gap_r=0 gives back-to-back VOUT.
- Latency: START sampled at edge k -> first VOUT=1 registered at edge k+1.
- DRAIN: VOUT=0, DOUT holds the last sample. drn_cnt decrements each edge; at 0 go to DONE and set END_SIM=1. END_SIM rises DRAIN_CYCLES+1 edges after the last VOUT edge.
- DONE: END_SIM=1, BUSY=0, VOUT=0. START is ignored; only reset leaves DONE.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Advances only on emitted samples.
  - The sequence restarts from the seed only on reset.
- START while BUSY or in DONE: ignored. GAP_CFG changes mid-run: ignored.
- Reset mid-run: immediate return to the reset state; no partial END_SIM.

Optional Feature:
- Macro: FIR_STIM_SYM_CLIP_EN.
- Defined: a sample equal to -2^(NB-1) (9'h100 for NB=9) is emitted as -2^(NB-1)+1 (9'h101). This keeps the input range symmetric so the multiplier never sees (-max)*(-max). LFSR state is unaffected.
- Undefined: raw LFSR bits are emitted unchanged.

Test Plan:
- Reset release with default H_INIT -> all outputs 0 except H0..H10 equal to their H_INIT slices; BUSY=0.
- START=1 at edge k, GAP_CFG=0, LFSR_SEED=16'hACE1 -> VOUT=1 at edges k+1 and k+2; DOUT=9'h0E1 (225), then 9'h1C3 (-61).
- N_SAMPLES=4, GAP_CFG=2, DRAIN_CYCLES=16 -> VOUT at edges k+1, k+4, k+7, k+10; END_SIM=1 at edge k+27 and stays high; START pulse afterwards -> no VOUT.
- GAP_CFG changed from 2 to 0 and START re-pulsed during RUN -> spacing stays 3 cycles; sample count unchanged.
- RST_n low mid-RUN after 2 samples -> VOUT/BUSY drop asynchronously; next START replays 225 as the first sample.
- FIR_STIM_SYM_CLIP_EN defined: force lfsr low bits to 9'h100 -> DOUT=9'h101. Undefined: DOUT=9'h100.

Source files
------------

// File: rtl/fir_stim_gen.sv
// fir_stim_gen: on-chip LFSR sample and coefficient source for the FIR datapath.
// Ports: CLK, RST_n, START, GAP_CFG[3:0] in; DOUT, VOUT, H0..H10, END_SIM, BUSY out.
// Option: FIR_STIM_SYM_CLIP_EN maps the most negative sample to -(2^(NB-1))+1.
module fir_stim_gen #(
  parameter int          NB           = 9,
  parameter int          N_SAMPLES    = 1024,
  parameter int          CNT_W        = 16,
  parameter int          DRAIN_CYCLES = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [11*NB-1:0] H_INIT  = {
    NB'(1), NB'(2), NB'(3), NB'(4), NB'(5), NB'(6),
    NB'(5), NB'(4), NB'(3), NB'(2), NB'(1)}
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          START,
  input  logic [3:0]    GAP_CFG,
  output logic [NB-1:0] DOUT,
  output logic          VOUT,
  output logic [NB-1:0] H0,
  output logic [NB-1:0] H1,
  output logic [NB-1:0] H2,
  output logic [NB-1:0] H3,
  output logic [NB-1:0] H4,
  output logic [NB-1:0] H5,
  output logic [NB-1:0] H6,
  output logic [NB-1:0] H7,
  output logic [NB-1:0] H8,
  output logic [NB-1:0] H9,
  output logic [NB-1:0] H10,
  output logic          END_SIM,
  output logic          BUSY
);

  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] DRN_INIT =
    CNT_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [3:0]       gap_r_q, gap_r_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [CNT_W-1:0] drn_cnt_q, drn_cnt_d;
  logic [NB-1:0]    dout_q, dout_d;
  logic             vout_q, vout_d;
  logic             end_q, end_d;
  logic             busy_q, busy_d;
  logic [NB-1:0]    h_q [11];

  logic             emit;
  logic             last;
  logic [NB-1:0]    samp;
  logic [15:0]      lfsr_nxt;

  assign emit = (state_q == S_RUN) && (gap_cnt_q == 4'd0);
  assign last = (smp_cnt_q == LAST_IDX);

  assign lfsr_nxt = {lfsr_q[14:0],
    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

`ifdef FIR_STIM_SYM_CLIP_EN
  localparam logic [NB-1:0] S_MIN = {1'b1, {(NB-1){1'b0}}};
  // Keep the range symmetric so no (-max)*(-max) product occurs.
  always_comb begin
    samp = lfsr_q[NB-1:0];
    if (samp == S_MIN) samp = S_MIN + NB'(1);
  end
`else
  assign samp = lfsr_q[NB-1:0];
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      gap_r_q   <= '0;
      gap_cnt_q <= '0;
      smp_cnt_q <= '0;
      drn_cnt_q <= '0;
      dout_q    <= '0;
      vout_q    <= 1'b0;
      end_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      gap_r_q   <= gap_r_d;
      gap_cnt_q <= gap_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      drn_cnt_q <= drn_cnt_d;
      dout_q    <= dout_d;
      vout_q    <= vout_d;
      end_q     <= end_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < 11; i++)
        h_q[i] <= H_INIT[i*NB +: NB];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (START) state_d = S_RUN;
      S_RUN:   if (emit && last) state_d = S_DRAIN;
      S_DRAIN: if (drn_cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lfsr_d    = lfsr_q;
    gap_r_d   = gap_r_q;
    gap_cnt_d = gap_cnt_q;
    smp_cnt_d = smp_cnt_q;
    drn_cnt_d = drn_cnt_q;
    dout_d    = dout_q;
    vout_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          gap_r_d   = GAP_CFG;
          gap_cnt_d = 4'd0;
          smp_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (emit) begin
          vout_d    = 1'b1;
          dout_d    = samp;
          lfsr_d    = lfsr_nxt;
          smp_cnt_d = smp_cnt_q + 1'b1;
          gap_cnt_d = gap_r_q;
          if (last) drn_cnt_d = DRN_INIT;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      S_DRAIN: begin
        if (drn_cnt_q != '0)
          drn_cnt_d = drn_cnt_q - 1'b1;
      end
      default: ;
    endcase
    end_d  = end_q || (state_d == S_DONE);
    busy_d = (state_d == S_RUN) ||
             (state_d == S_DRAIN);
  end

  assign DOUT    = dout_q;
  assign VOUT    = vout_q;
  assign END_SIM = end_q;
  assign BUSY    = busy_q;
  assign H0      = h_q[0];
  assign H1      = h_q[1];
  assign H2      = h_q[2];
  assign H3      = h_q[3];
  assign H4      = h_q[4];
  assign H5      = h_q[5];
  assign H6      = h_q[6];
  assign H7      = h_q[7];
  assign H8      = h_q[8];
  assign H9      = h_q[9];
  assign H10     = h_q[10];

endmodule

// File: tb/tb_fir_stim_gen.sv
// tb_fir_stim_gen: scoreboard bench for fir_stim_gen.
// Main instance: 4 samples, drain 16; second instance exercises the clip path.
module tb_fir_stim_gen;

  localparam int NB = 9;
  localparam logic [11*NB-1:0] HI = {
    9'h1F0, 9'h011, 9'h022, 9'h133, 9'h044, 9'h0FF,
    9'h055, 9'h166, 9'h077, 9'h188, 9'h099};

  logic          CLK = 1'b0;
  logic          RST_n;
  logic          START;
  logic [3:0]    GAP_CFG;
  logic [NB-1:0] DOUT;
  logic          VOUT;
  logic          END_SIM;
  logic          BUSY;
  logic [NB-1:0] h_a [11];

  logic          START2;
  logic [NB-1:0] DOUT2;
  logic          VOUT2;
  logic          END2;
  logic          BUSY2;
  logic [NB-1:0] h_b [11];

  int n_cmp = 0;
  int n_err = 0;
  logic [NB-1:0] exp_q [$];
  logic [15:0]   m_lfsr;
  logic [NB-1:0] last_s;
  logic [NB-1:0] e;
  int            n_v;

  always #5 CLK = ~CLK;

  fir_stim_gen #(
    .NB(NB), .N_SAMPLES(4), .CNT_W(16),
    .DRAIN_CYCLES(16), .LFSR_SEED(16'hACE1),
    .H_INIT(HI)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .START(START),
    .GAP_CFG(GAP_CFG), .DOUT(DOUT), .VOUT(VOUT),
    .H0(h_a[0]), .H1(h_a[1]), .H2(h_a[2]),
    .H3(h_a[3]), .H4(h_a[4]), .H5(h_a[5]),
    .H6(h_a[6]), .H7(h_a[7]), .H8(h_a[8]),
    .H9(h_a[9]), .H10(h_a[10]),
    .END_SIM(END_SIM), .BUSY(BUSY)
  );

  fir_stim_gen #(
    .NB(NB), .N_SAMPLES(2), .CNT_W(16),
    .DRAIN_CYCLES(2), .LFSR_SEED(16'h0100),
    .H_INIT(HI)
  ) u_clip (
    .CLK(CLK), .RST_n(RST_n), .START(START2),
    .GAP_CFG(4'd0), .DOUT(DOUT2), .VOUT(VOUT2),
    .H0(h_b[0]), .H1(h_b[1]), .H2(h_b[2]),
    .H3(h_b[3]), .H4(h_b[4]), .H5(h_b[5]),
    .H6(h_b[6]), .H7(h_b[7]), .H8(h_b[8]),
    .H9(h_b[9]), .H10(h_b[10]),
    .END_SIM(END2), .BUSY(BUSY2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, act, exp);
    end
  endtask

  function automatic logic [15:0] nxt(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [NB-1:0] clip(input logic [NB-1:0] s);
`ifdef FIR_STIM_SYM_CLIP_EN
    if (s == 9'h100) return 9'h101;
`endif
    return s;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_run(input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(clip(m_lfsr[NB-1:0]));
      m_lfsr = nxt(m_lfsr);
    end
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, 32'(1), 32'(0));
    end else begin
      e = exp_q.pop_front();
      last_s = e;
      chk(tag, 32'(DOUT), 32'(e));
    end
  endtask

  task automatic do_reset();
    RST_n = 1'b0;
    exp_q.delete();
    m_lfsr = 16'hACE1;
    tick();
    tick();
  endtask

  initial begin
    RST_n   = 1'b0;
    START   = 1'b0;
    START2  = 1'b0;
    GAP_CFG = 4'd0;
    last_s  = '0;
    n_v     = 0;
    do_reset();

    chk("rst_vout", 32'(VOUT), 32'(0));
    chk("rst_dout", 32'(DOUT), 32'(0));
    chk("rst_end", 32'(END_SIM), 32'(0));
    chk("rst_busy", 32'(BUSY), 32'(0));
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("rst_h%0d", i),
          32'(h_a[i]), 32'(HI[i*NB +: NB]));
      chk($sformatf("clip_h%0d", i),
          32'(h_b[i]), 32'(HI[i*NB +: NB]));
    end
    RST_n = 1'b1;
    tick();

    // back-to-back run, aborted by reset after two samples
    GAP_CFG = 4'd0;
    START = 1'b1;
    push_run(4);
    tick();
    START = 1'b0;
    chk("k_busy", 32'(BUSY), 32'(1));
    chk("k_vout", 32'(VOUT), 32'(0));
    tick();
    chk("g0_v1", 32'(VOUT), 32'(1));
    chk("g0_d1", 32'(DOUT), 32'(9'h0E1));
    pop_chk("g0_s1");
    tick();
    chk("g0_v2", 32'(VOUT), 32'(1));
    chk("g0_d2", 32'(DOUT), 32'(9'h1C3));
    pop_chk("g0_s2");
    #3;
    RST_n = 1'b0;
    #1;
    chk("ar_vout", 32'(VOUT), 32'(0));
    chk("ar_busy", 32'(BUSY), 32'(0));
    chk("ar_dout", 32'(DOUT), 32'(0));
    do_reset();
    chk("ar_end", 32'(END_SIM), 32'(0));
    RST_n = 1'b1;
    tick();

    // full run with gap 2; mid-run GAP/START changes ignored
    GAP_CFG = 4'd2;
    START = 1'b1;
    push_run(4);
    tick();
    START = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 2) begin
        GAP_CFG = 4'd0;
        START = 1'b1;
      end
      if (i == 4) START = 1'b0;
      tick();
      chk($sformatf("v_e%0d", i), 32'(VOUT),
          32'((i <= 10) && ((i - 1) % 3 == 0)));
      chk($sformatf("end_e%0d", i), 32'(END_SIM),
          32'(i >= 27));
      chk($sformatf("busy_e%0d", i), 32'(BUSY),
          32'(i < 27));
      if (i == 1) chk("replay", 32'(DOUT), 32'(9'h0E1));
      if (VOUT) begin
        n_v++;
        pop_chk($sformatf("smp_e%0d", i));
      end
      if (i == 15) chk("drain_hold", 32'(DOUT), 32'(last_s));
    end
    chk("n_smp", 32'(n_v), 32'(4));
    chk("q_left", 32'(exp_q.size()), 32'(0));

    // START in DONE is ignored
    START = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) START = 1'b0;
      tick();
      chk($sformatf("done_v%0d", i), 32'(VOUT), 32'(0));
      chk($sformatf("done_e%0d", i), 32'(END_SIM), 32'(1));
    end

    // clip instance: seed low bits 9'h100
    START2 = 1'b1;
    tick();
    START2 = 1'b0;
    tick();
    chk("clip_v1", 32'(VOUT2), 32'(1));
    chk("clip_d1", 32'(DOUT2), 32'(clip(9'h100)));
    tick();
    chk("clip_v2", 32'(VOUT2), 32'(1));
    chk("clip_d2", 32'(DOUT2), 32'(9'h000));
    for (int i = 0; i < 3; i++) tick();
    chk("clip_end", 32'(END2), 32'(1));
    chk("clip_busy", 32'(BUSY2), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
